// File: rtl/mem_arb_pkg.sv
// Shared types, AXI response codes and the cyclic priority pick used by the
// read-channel arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned MAX_IDX_W   = 3;

  // One-hot grant of the first set bit of req at or above ptr, wrapping at n.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input int unsigned            ptr,
    input int unsigned            n
  );
    logic [MAX_MASTERS-1:0] gnt;
    logic                   found;
    int unsigned            idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_MASTERS; off++) begin
      idx = ptr + off;
      if (idx >= n) idx = idx - n;
      if (!found && off < n && idx < n && req[idx[MAX_IDX_W-1:0]]) begin
        gnt[idx[MAX_IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational cyclic priority picker; fixed-priority mode searches from 0.
module arb_rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter bit          RR_MODE = 1'b1,
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_MASTERS-1:0] gnt_ext;

  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    gnt_ext          = rr_pick(req_ext, RR_MODE ? 32'(ptr) : 32'd0, N);
    gnt_idx          = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_ext[i]) gnt_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// N-master AXI4 read-channel arbiter: one outstanding burst, fixed or
// round-robin grant, combinational R pass-through and sticky error capture.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RR_MODE   = 1,
  localparam int unsigned IDX_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_MASTERS-1:0]        m_arvalid,
  output logic [N_MASTERS-1:0]        m_arready,
  input  logic [N_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [N_MASTERS*8-1:0]      m_arlen,
  input  logic [N_MASTERS*3-1:0]      m_arsize,
  output logic [N_MASTERS-1:0]        m_rvalid,
  input  logic [N_MASTERS-1:0]        m_rready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [1:0]                  m_rresp,
  output logic                        m_rlast,
  output logic                        ram_arvalid,
  input  logic                        ram_arready,
  output logic [ADDR_W-1:0]           ram_araddr,
  output logic [7:0]                  ram_arlen,
  output logic [2:0]                  ram_arsize,
  input  logic                        ram_rvalid,
  output logic                        ram_rready,
  input  logic [DATA_W-1:0]           ram_rdata,
  input  logic [1:0]                  ram_rresp,
  input  logic                        ram_rlast,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        err_sticky,
  output logic [IDX_W-1:0]            err_master
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             err_sticky_q;
  logic [IDX_W-1:0] err_master_q;
  logic             r_hs;
  logic             resp_err;

  if (N_MASTERS > 1) begin : g_pick
    arb_rr_picker #(
      .N       (N_MASTERS),
      .RR_MODE (RR_MODE != 0)
    ) u_picker (
      .req     (m_arvalid),
      .ptr     (rr_ptr_q),
      .gnt_idx (pick_idx)
    );
  end else begin : g_single
    assign pick_idx = '0;
  end

  assign next_ptr = (grant_q == IDX_W'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
  assign r_hs     = (state_q == DATA) && ram_rvalid && m_rready[grant_q];
  assign resp_err = (ram_rresp == RESP_SLVERR) || (ram_rresp == RESP_DECERR);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    m_arready   = '0;
    m_rvalid    = '0;
    ram_arvalid = 1'b0;
    ram_rready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|m_arvalid) begin
          grant_d = pick_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        ram_arvalid         = m_arvalid[grant_q];
        m_arready[grant_q]  = ram_arready;
        if (m_arvalid[grant_q] && ram_arready) state_d = DATA;
      end
      DATA: begin
        m_rvalid[grant_q] = ram_rvalid;
        ram_rready        = m_rready[grant_q];
        if (r_hs && ram_rlast) begin
          state_d = IDLE;
          if (RR_MODE != 0) rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // AR fields follow the registered grant; only ram_arvalid qualifies them.
  assign ram_araddr = m_araddr[grant_q*ADDR_W +: ADDR_W];
  assign ram_arlen  = m_arlen[grant_q*8 +: 8];
  assign ram_arsize = m_arsize[grant_q*3 +: 3];

  assign m_rdata = ram_rdata;
  assign m_rresp = ram_rresp;
  assign m_rlast = ram_rlast;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      err_sticky_q <= 1'b0;
      err_master_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      if (r_hs && resp_err) begin
        err_sticky_q <= 1'b1;
        if (!err_sticky_q) err_master_q <= grant_q;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign grant_idx  = grant_q;
  assign err_sticky = err_sticky_q;
  assign err_master = err_master_q;

  a_arvalid_held: assert property (
    @(posedge clock) disable iff (reset) (state_q == ADDR) |-> m_arvalid[grant_q]
  );

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: a round-robin and a fixed-priority instance
// driven side by side, checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_read_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0]    m_arvalid[2], m_arready[2], m_rvalid[2], m_rready[2];
  logic [N*AW-1:0] m_araddr[2];
  logic [N*8-1:0]  m_arlen[2];
  logic [N*3-1:0]  m_arsize[2];
  logic [DW-1:0]   m_rdata[2];
  logic [1:0]      m_rresp[2];
  logic            m_rlast[2];
  logic            ram_arvalid[2], ram_arready[2];
  logic [AW-1:0]   ram_araddr[2];
  logic [7:0]      ram_arlen[2];
  logic [2:0]      ram_arsize[2];
  logic            ram_rvalid[2], ram_rready[2], ram_rlast[2];
  logic [DW-1:0]   ram_rdata[2];
  logic [1:0]      ram_rresp[2];
  logic            busy[2], err_sticky[2];
  logic [1:0]      grant_idx[2], err_master[2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_read_arbiter #(
      .N_MASTERS (N),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .RR_MODE   (k == 0 ? 1 : 0)
    ) dut (
      .clock       (clock),
      .reset       (reset),
      .m_arvalid   (m_arvalid[k]),
      .m_arready   (m_arready[k]),
      .m_araddr    (m_araddr[k]),
      .m_arlen     (m_arlen[k]),
      .m_arsize    (m_arsize[k]),
      .m_rvalid    (m_rvalid[k]),
      .m_rready    (m_rready[k]),
      .m_rdata     (m_rdata[k]),
      .m_rresp     (m_rresp[k]),
      .m_rlast     (m_rlast[k]),
      .ram_arvalid (ram_arvalid[k]),
      .ram_arready (ram_arready[k]),
      .ram_araddr  (ram_araddr[k]),
      .ram_arlen   (ram_arlen[k]),
      .ram_arsize  (ram_arsize[k]),
      .ram_rvalid  (ram_rvalid[k]),
      .ram_rready  (ram_rready[k]),
      .ram_rdata   (ram_rdata[k]),
      .ram_rresp   (ram_rresp[k]),
      .ram_rlast   (ram_rlast[k]),
      .busy        (busy[k]),
      .grant_idx   (grant_idx[k]),
      .err_sticky  (err_sticky[k]),
      .err_master  (err_master[k])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Environment knobs and per-instance master / slave state.
  bit          rst_req;
  int          req_rate, max_len, rready_mode, arready_pct, rvalid_pct, err_rand;
  bit          req_q[2][N], cont[2][N];
  logic [31:0] req_addr[2][N];
  logic [7:0]  req_len[2][N];
  bit          rready_tog[2];
  bit          s_act[2], s_valid[2];
  logic [31:0] s_addr[2];
  logic [7:0]  s_len[2], s_beat[2];
  int          err_beat[2];

  // Reference model: phase 0 idle, 1 address, 2 data.
  int          ph[2], g[2], ptr[2], merrm[2], m_beat[2];
  bit          merr[2];
  logic [31:0] m_base[2];
  logic [7:0]  m_blen[2];
  int          beats_rx[2][N];
  int          glog[2][$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int ref_pick(input logic [N-1:0] req, input int start);
    for (int i = 0; i < N; i++) if (req[(start + i) % N]) return (start + i) % N;
    return 0;
  endfunction

  function automatic logic [31:0] beat_data(input logic [31:0] a, input logic [7:0] b);
    return a ^ ({24'h0, b} * 32'h0101_0101) ^ 32'h5A00_0000;
  endfunction

  task automatic new_req(input int k, input int m, input logic [31:0] a, input int len);
    req_q[k][m]    = 1'b1;
    req_addr[k][m] = a;
    req_len[k][m]  = 8'(len);
  endtask

  task automatic drive(input int k);
    for (int m = 0; m < N; m++) begin
      if (!req_q[k][m] && req_rate > 0 && $urandom_range(99) < req_rate)
        new_req(k, m, $urandom & 32'hFFFF_FFFC, $urandom_range(max_len));
      m_arvalid[k][m]          = req_q[k][m];
      m_araddr[k][m*AW +: AW]  = req_addr[k][m];
      m_arlen[k][m*8 +: 8]     = req_len[k][m];
      m_arsize[k][m*3 +: 3]    = 3'd2;
      m_rready[k][m] = (rready_mode == 2) ? 1'b1 :
                       (rready_mode == 1) ? rready_tog[k] : 1'($urandom_range(1));
    end
    rready_tog[k]  = ~rready_tog[k];
    ram_arready[k] = ($urandom_range(99) < arready_pct);
    if (s_act[k] && !s_valid[k] && $urandom_range(99) < rvalid_pct) begin
      s_valid[k]   = 1'b1;
      ram_rdata[k] = beat_data(s_addr[k], s_beat[k]);
      ram_rlast[k] = (s_beat[k] == s_len[k]);
      if (int'(s_beat[k]) == err_beat[k])              ram_rresp[k] = RESP_SLVERR;
      else if (err_rand != 0 && $urandom_range(40) == 0) ram_rresp[k] = RESP_DECERR;
      else                                               ram_rresp[k] = RESP_OKAY;
    end
    ram_rvalid[k] = s_valid[k];
  endtask

  task automatic evaluate(input int k);
    int gi;
    logic [N-1:0] exp_v;
    string sfx;
    gi  = g[k];
    sfx = $sformatf("[%0d]", k);
    check_eq({"busy", sfx}, busy[k], ph[k] != 0);
    check_eq({"grant_idx", sfx}, grant_idx[k], gi);
    check_eq({"err_sticky", sfx}, err_sticky[k], merr[k]);
    check_eq({"err_master", sfx}, err_master[k], merrm[k]);
    exp_v = (ph[k] == 1 && ram_arready[k]) ? N'(1 << gi) : '0;
    check_eq({"m_arready", sfx}, m_arready[k], exp_v);
    check_eq({"ram_arvalid", sfx}, ram_arvalid[k], ph[k] == 1 && req_q[k][gi]);
    if (ph[k] == 1) begin
      check_eq({"ram_araddr", sfx}, ram_araddr[k], req_addr[k][gi]);
      check_eq({"ram_arlen", sfx}, ram_arlen[k], req_len[k][gi]);
    end
    exp_v = (ph[k] == 2 && s_valid[k]) ? N'(1 << gi) : '0;
    check_eq({"m_rvalid", sfx}, m_rvalid[k], exp_v);
    check_eq({"ram_rready", sfx}, ram_rready[k], ph[k] == 2 && m_rready[k][gi]);
    if (ph[k] == 2 && s_valid[k])
      check_eq({"r_passthru", sfx}, {m_rdata[k], m_rresp[k], m_rlast[k]},
               {ram_rdata[k], ram_rresp[k], ram_rlast[k]});

    if (reset) begin
      ph[k] = 0; g[k] = 0; ptr[k] = 0; merr[k] = 0; merrm[k] = 0; m_beat[k] = 0;
      s_act[k] = 0; s_valid[k] = 0;
      for (int m = 0; m < N; m++) req_q[k][m] = 0;
    end else if (ph[k] == 0) begin
      if (|m_arvalid[k]) begin
        g[k] = ref_pick(m_arvalid[k], (k == 0) ? ptr[k] : 0);
        glog[k].push_back(g[k]);
        ph[k] = 1;
      end
    end else if (ph[k] == 1) begin
      if (req_q[k][gi] && ram_arready[k]) begin
        ph[k] = 2; m_beat[k] = 0;
        m_base[k] = req_addr[k][gi]; m_blen[k] = req_len[k][gi];
        s_act[k] = 1; s_beat[k] = 0; s_addr[k] = ram_araddr[k]; s_len[k] = ram_arlen[k];
        req_q[k][gi] = 0;
        if (cont[k][gi]) new_req(k, gi, $urandom & 32'hFFFF_FFFC, 0);
      end
    end else if (s_valid[k] && m_rready[k][gi]) begin
      check_eq({"beat_data", sfx}, m_rdata[k], beat_data(m_base[k], 8'(m_beat[k])));
      check_eq({"beat_last", sfx}, m_rlast[k], m_beat[k] == int'(m_blen[k]));
      if (ram_rresp[k][1]) begin
        if (!merr[k]) merrm[k] = gi;
        merr[k] = 1;
      end
      beats_rx[k][gi]++;
      m_beat[k]++; s_beat[k]++; s_valid[k] = 0;
      if (ram_rlast[k]) begin
        ph[k] = 0; s_act[k] = 0;
        if (k == 0) ptr[k] = (gi + 1) % N;
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    reset = rst_req;
    for (int k = 0; k < 2; k++) drive(k);
    #1;
    for (int k = 0; k < 2; k++) evaluate(k);
  endtask

  function automatic bit any_pending();
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < N; m++) if (req_q[k][m] || cont[k][m]) return 1;
    return (ph[0] != 0) || (ph[1] != 0);
  endfunction

  task automatic drain(input string tag);
    int c = 0;
    while (any_pending() && c < 400) begin step(); c++; end
    check_eq({tag, "_drain"}, c < 400, 1);
  endtask

  task automatic wait_grants(input int n, input string tag);
    int c = 0;
    while ((glog[0].size() < n || glog[1].size() < n) && c < 400) begin step(); c++; end
    check_eq({tag, "_grants"}, c < 400, 1);
  endtask

  task automatic do_reset();
    rst_req = 1; step(); rst_req = 0; step();
    for (int k = 0; k < 2; k++) glog[k].delete();
  endtask

  task automatic req_both(input int m, input logic [31:0] a, input int len);
    for (int k = 0; k < 2; k++) new_req(k, m, a, len);
  endtask

  initial begin
    int c;
    reset = 1'b1; rst_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_arvalid[k] = '0; m_araddr[k] = '0; m_arlen[k] = '0; m_arsize[k] = '0; m_rready[k] = '0;
      ram_arready[k] = 0; ram_rvalid[k] = 0; ram_rdata[k] = '0; ram_rresp[k] = '0; ram_rlast[k] = 0;
      err_beat[k] = -1; glog[k].delete();
      for (int m = 0; m < N; m++) begin beats_rx[k][m] = 0; req_q[k][m] = 0; cont[k][m] = 0; end
    end
    req_rate = 0; max_len = 0; rready_mode = 2; arready_pct = 100; rvalid_pct = 100; err_rand = 0;
    @(posedge clock);
    rst_req = 1'b0;
    step();
    for (int k = 0; k < 2; k++)
      check_eq("reset_outputs", {m_arready[k], m_rvalid[k], ram_arvalid[k], ram_rready[k],
                                 busy[k], grant_idx[k], err_sticky[k], err_master[k]}, '0);

    // Single master 1, 4-beat burst.
    req_both(1, 32'h8000_0000, 3);
    drain("single");
    for (int k = 0; k < 2; k++) begin
      check_eq("single_grant", glog[k][0], 1);
      check_eq("single_beats", {beats_rx[k][0], beats_rx[k][1], beats_rx[k][2]}, {32'd0, 32'd4, 32'd0});
    end

    // All masters continuously requesting single beats.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < N; m++) begin cont[k][m] = 1; new_req(k, m, 32'h100 * (m + 1), 0); end
    wait_grants(6, "cont");
    for (int i = 0; i < 6; i++) begin
      check_eq("rr_order", glog[0][i], i % N);
      check_eq("fixed_order", glog[1][i], 0);
    end
    for (int k = 0; k < 2; k++) begin cont[k][0] = 0; cont[k][1] = 0; end
    wait_grants(8, "release");
    check_eq("rr_after_release", {glog[0][6], glog[0][7]}, {32'd0, 32'd1});
    check_eq("fixed_after_release", {glog[1][6], glog[1][7]}, {32'd1, 32'd2});
    for (int k = 0; k < 2; k++) cont[k][2] = 0;
    drain("cont");

    // Toggling rready on the granted master.
    rready_mode = 1;
    for (int k = 0; k < 2; k++) beats_rx[k][2] = 0;
    req_both(2, 32'h0000_4000, 7);
    drain("toggle");
    for (int k = 0; k < 2; k++) check_eq("toggle_beats", beats_rx[k][2], 8);
    rready_mode = 2;

    // Error on beat 2 of a master-0 burst, then an error to master 2.
    do_reset();
    for (int k = 0; k < 2; k++) err_beat[k] = 2;
    req_both(0, 32'h0000_1000, 3);
    drain("err0");
    for (int k = 0; k < 2; k++) check_eq("err_first", {err_sticky[k], err_master[k]}, {1'b1, 2'd0});
    for (int k = 0; k < 2; k++) err_beat[k] = 1;
    req_both(2, 32'h0000_2000, 3);
    drain("err2");
    for (int k = 0; k < 2; k++) begin
      check_eq("err_keep", {err_sticky[k], err_master[k]}, {1'b1, 2'd0});
      err_beat[k] = -1;
    end

    // Randomised traffic with back-pressure on every interface.
    req_rate = 20; max_len = 5; rready_mode = 0; arready_pct = 60; rvalid_pct = 60; err_rand = 1;
    repeat (1500) step();
    req_rate = 0;
    drain("random");
    for (int k = 0; k < 2; k++) check_eq("err_hold_random", err_sticky[k], 1);
    rready_mode = 2; arready_pct = 100; rvalid_pct = 100; err_rand = 0;

    // Reset during beat 1 of a 4-beat burst after moving rr_ptr off zero.
    do_reset();
    req_both(1, 32'h0000_3000, 0);
    drain("pre_abort");
    req_both(1, 32'h0000_5000, 3);
    c = 0;
    while (!(ph[0] == 2 && m_beat[0] == 1) && c < 50) begin step(); c++; end
    check_eq("abort_reach_beat1", c < 50, 1);
    rst_req = 1; step(); rst_req = 0; step();
    for (int k = 0; k < 2; k++)
      check_eq("abort_outputs", {m_arready[k], m_rvalid[k], ram_arvalid[k], ram_rready[k],
                                 busy[k], err_sticky[k]}, '0);
    for (int k = 0; k < 2; k++) glog[k].delete();
    req_both(1, 32'h0000_6000, 1);
    req_both(2, 32'h0000_7000, 1);
    wait_grants(2, "post_abort");
    for (int k = 0; k < 2; k++) check_eq("post_abort_order", {glog[k][0], glog[k][1]}, {32'd1, 32'd2});
    drain("post_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Parametrised N-master AXI4 read-channel arbiter; successor to the fixed 3-port IFU/LSU/MMU memory arbiter.
- Sits between the requesters (IFU, LSU, MMU, future D-cache refill) and the XBar read port.
- One outstanding burst at a time; selectable fixed-priority or round-robin grant; sticky error reporting.

Parameters:
- N_MASTERS, 3, number of requesting masters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m_arvalid  in  N_MASTERS  per-master AR valid
- m_arready  out  N_MASTERS  per-master AR ready
- m_araddr  in  N_MASTERS*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
- m_arlen  in  N_MASTERS*8  per-master burst length
- m_arsize  in  N_MASTERS*3  per-master beat size
- m_rvalid  out  N_MASTERS  per-master R valid
- m_rready  in  N_MASTERS  per-master R ready
- m_rdata  out  DATA_W  R data, broadcast to all masters
- m_rresp  out  2  R response, broadcast
- m_rlast  out  1  R last, broadcast
- ram_arvalid / ram_arready / ram_araddr / ram_arlen / ram_arsize  out/in/out/out/out  1/1/ADDR_W/8/3  downstream AR
- ram_rvalid / ram_rready / ram_rdata / ram_rresp / ram_rlast  in/out/in/in/in  1/1/DATA_W/2/1  downstream R
- busy  out  1  state != IDLE
- grant_idx  out  $clog2(N_MASTERS)  current or last granted master
- err_sticky  out  1  set on any R beat with rresp[1]=1
- err_master  out  $clog2(N_MASTERS)  master that received the first error

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant_idx=0, err_sticky=0, err_master=0.
- Reset outputs: all m_arready, m_rvalid, ram_arvalid and ram_rready are 0.
- A reset asserted mid-burst aborts the transaction immediately. Downstream cleanup is the SoC's responsibility.
- IDLE:
  - If any m_arvalid is set, select the winner, register grant_idx, go to ADDR.
  - Nothing is forwarded in this cycle, so arbitration costs 1 bubble cycle.
  - Fixed mode: lowest asserted index wins.
  - RR mode: first asserted index at or above rr_ptr, searching cyclically, wraps N_MASTERS-1 to 0.
- ADDR:
  - ram_arvalid = m_arvalid[grant]; AR fields are muxed from the granted master.
  - m_arready[grant] = ram_arready; all other m_arready = 0.
  - On the AR handshake, go to DATA.
  - Masters must hold arvalid until the handshake (AXI rule). A deassert while in ADDR is a protocol violation: assertion failure in simulation, no recovery required.
- DATA:
  - m_rvalid[grant] = ram_rvalid, others 0; ram_rready = m_rready[grant].
  - R fields pass straight through combinationally, 0 added latency, back-pressure honoured.
  - On a handshake with ram_rlast=1: go to IDLE; in RR mode, rr_ptr = grant+1 mod N_MASTERS.
  - A handshake without ram_rlast stays in DATA.
- Non-granted masters see no handshake. Their requests wait and are never dropped.
- Errors: on any R handshake with ram_rresp[1]=1, set err_sticky. If err_sticky was 0, also capture err_master=grant. err_sticky clears only on reset.
- Latency: AR issues at the earliest 1 cycle after a request is first seen in IDLE.
- Back-to-back bursts: the next grant is decided in the IDLE cycle right after the last beat, so there is a 1-cycle gap.
- Fairness (RR mode): with all masters requesting continuously, each master is granted once per N_MASTERS transactions.
- N_MASTERS=1: no arbitration logic; grant_idx is constant 0.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef arb_state_t {IDLE, ADDR, DATA}
  - AXI resp constants RESP_OKAY, RESP_SLVERR, RESP_DECERR
  - function rr_pick(req, ptr) returning a one-hot grant
- One sub-module, arb_rr_picker: combinational cyclic priority picker, parametrised on N, with RR_MODE selecting ptr or 0.
- The top holds the FSM, the muxes and the error logic.

Test Plan:
- Single master 1 requests araddr=0x8000_0000, arlen=3:
  - ram_arvalid rises 1 cycle after the request.
  - 4 beats route only to m_rvalid[1].
  - busy drops the cycle after the rlast handshake.
- RR mode, all 3 masters request continuously for 6 single-beat transactions -> grant order 0,1,2,0,1,2.
- Fixed mode, same stimulus -> grant order 0,0,0,... Master 2 is served only after master 0 and master 1 deassert.
- DATA phase with m_rready[grant] toggling 1,0,1,0 -> ram_rready mirrors it. No beat is lost or duplicated, and the data order matches the downstream order.
- Master 0 receives beat 2 with rresp=2'b10, then master 2 receives an error:
  - err_sticky=1 after beat 2 of master 0.
  - err_master=0 and stays 0.
  - err_sticky stays 1 until reset.
- Reset asserted during DATA beat 1 of 4:
  - Next cycle: state IDLE, all valid/ready outputs 0, rr_ptr=0.
  - A new request after reset is granted normally.
